// File: rtl/bp_burst_cmd_store_fwd_pkg.sv
// Shared definitions for the burst mem_cmd store-and-forward stage:
// FSM state encoding and the header-size to beat-count helper.
package bp_burst_cmd_store_fwd_pkg;

  typedef enum logic [1:0] {
    e_ready,
    e_collect,
    e_send_hdr,
    e_send_data
  } state_e;

  // Number of data beats carried by a payload message of 2**size bytes.
  // Sub-beat sizes still occupy one beat; oversize requests clamp to the buffer depth.
  function automatic int unsigned size_to_beats(input logic [2:0] size,
                                                input int unsigned data_width,
                                                input int unsigned max_beats);
    int unsigned n;
    n = (32'd8 << size) / data_width;
    if (n == 0) n = 1;
    if (n > max_beats) n = max_beats;
    return n;
  endfunction

endpackage

// File: rtl/bp_burst_beat_buffer.sv
// Flop-based beat buffer: els_p entries of data_width_p bits, one write port,
// one asynchronous read port. Contents are not reset; the control logic only
// reads entries it has written for the current message.
//   clk_i     clock
//   w_v_i     write enable
//   w_addr_i  write index
//   w_data_i  write data
//   r_addr_i  read index
//   r_data_o  read data (combinational from the flops)
module bp_burst_beat_buffer #(
  parameter int unsigned data_width_p = 64,
  parameter int unsigned els_p        = 8,
  parameter int unsigned addr_width_p = 3
) (
  input  logic                    clk_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [data_width_p-1:0] w_data_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [data_width_p-1:0] r_data_o
);

  logic [data_width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_burst_cmd_store_fwd.sv
// Store-and-forward stage for burst mem_cmd messages (header + data beats).
// A header is held until all of its beats are buffered, then header and beats
// are replayed back-to-back. One message in flight at a time.
//   clk_i / reset_n_i                  clock, async active-low reset
//   hdr_i, hdr_v_i, hdr_ready_and_o    incoming header (valid/ready)
//   data_i, data_v_i, data_ready_and_o incoming data beats
//   hdr_o, hdr_v_o, hdr_ready_and_i    forwarded header (registered)
//   data_o, data_v_o, data_ready_and_i forwarded beats from the buffer
//   busy_o                             a message is held (state != READY)
module bp_burst_cmd_store_fwd
  import bp_burst_cmd_store_fwd_pkg::*;
#(
  parameter int unsigned  data_width_p   = 64,
  parameter int unsigned  block_width_p  = 512,
  parameter int unsigned  header_width_p = 64,
  parameter int unsigned  msg_type_lsb_p = 0,
  parameter int unsigned  size_lsb_p     = 4,
  parameter logic [15:0]  payload_mask_p = 16'h0002
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [header_width_p-1:0] hdr_i,
  input  logic                      hdr_v_i,
  output logic                      hdr_ready_and_o,
  input  logic [data_width_p-1:0]   data_i,
  input  logic                      data_v_i,
  output logic                      data_ready_and_o,
  output logic [header_width_p-1:0] hdr_o,
  output logic                      hdr_v_o,
  input  logic                      hdr_ready_and_i,
  output logic [data_width_p-1:0]   data_o,
  output logic                      data_v_o,
  input  logic                      data_ready_and_i,
  output logic                      busy_o
);

  localparam int unsigned max_beats_lp  = block_width_p / data_width_p;
  localparam int unsigned addr_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
  localparam int unsigned cnt_width_lp  = $clog2(max_beats_lp) + 1;

  state_e                  state;
  logic [cnt_width_lp-1:0] beats_r, wr_cnt, rd_cnt;
  logic [cnt_width_lp-1:0] beats_n, last_idx;
  logic [3:0]              msg_type;
  logic [2:0]              size;
  logic                    has_payload;
  logic                    wr_v;

  assign msg_type    = hdr_i[msg_type_lsb_p +: 4];
  assign size        = hdr_i[size_lsb_p +: 3];
  assign has_payload = payload_mask_p[msg_type];
  assign beats_n     = has_payload
                     ? cnt_width_lp'(size_to_beats(size, data_width_p, max_beats_lp))
                     : '0;
  assign last_idx    = beats_r - cnt_width_lp'(1);

  // data_ready_and_o is only high in COLLECT, so this is the input beat handshake.
  assign wr_v = data_v_i & data_ready_and_o;

  bp_burst_beat_buffer #(
    .data_width_p (data_width_p),
    .els_p        (max_beats_lp),
    .addr_width_p (addr_width_lp)
  ) beat_buffer (
    .clk_i    (clk_i),
    .w_v_i    (wr_v),
    .w_addr_i (wr_cnt[addr_width_lp-1:0]),
    .w_data_i (data_i),
    .r_addr_i (rd_cnt[addr_width_lp-1:0]),
    .r_data_o (data_o)
  );

  // Handshake and valid outputs are registered alongside the state so each
  // one is a direct decode of the state being entered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= e_ready;
      hdr_ready_and_o  <= 1'b1;
      data_ready_and_o <= 1'b0;
      hdr_v_o          <= 1'b0;
      data_v_o         <= 1'b0;
      busy_o           <= 1'b0;
      hdr_o            <= '0;
      beats_r          <= '0;
      wr_cnt           <= '0;
      rd_cnt           <= '0;
    end else begin
      case (state)
        e_ready: begin
          if (hdr_v_i) begin
            hdr_o           <= hdr_i;
            beats_r         <= beats_n;
            wr_cnt          <= '0;
            rd_cnt          <= '0;
            hdr_ready_and_o <= 1'b0;
            busy_o          <= 1'b1;
            if (beats_n == '0) begin
              state   <= e_send_hdr;
              hdr_v_o <= 1'b1;
            end else begin
              state            <= e_collect;
              data_ready_and_o <= 1'b1;
            end
          end
        end
        e_collect: begin
          if (data_v_i) begin
            if (wr_cnt == last_idx) begin
              state            <= e_send_hdr;
              data_ready_and_o <= 1'b0;
              hdr_v_o          <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + cnt_width_lp'(1);
            end
          end
        end
        e_send_hdr: begin
          if (hdr_ready_and_i) begin
            hdr_v_o <= 1'b0;
            if (beats_r == '0) begin
              state           <= e_ready;
              hdr_ready_and_o <= 1'b1;
              busy_o          <= 1'b0;
              wr_cnt          <= '0;
              rd_cnt          <= '0;
            end else begin
              state    <= e_send_data;
              data_v_o <= 1'b1;
            end
          end
        end
        e_send_data: begin
          if (data_ready_and_i) begin
            if (rd_cnt == last_idx) begin
              state           <= e_ready;
              data_v_o        <= 1'b0;
              hdr_ready_and_o <= 1'b1;
              busy_o          <= 1'b0;
              wr_cnt          <= '0;
              rd_cnt          <= '0;
            end else begin
              rd_cnt <= rd_cnt + cnt_width_lp'(1);
            end
          end
        end
        default: begin
          state            <= e_ready;
          hdr_ready_and_o  <= 1'b1;
          data_ready_and_o <= 1'b0;
          hdr_v_o          <= 1'b0;
          data_v_o         <= 1'b0;
          busy_o           <= 1'b0;
        end
      endcase
    end
  end

endmodule
